int_add_result_accumulator: RTL and testbench

- Downstream consumer of the configurable approximate integer adder: takes its signed result stream (c) and accumulates FRAME_LEN results per frame into a wide signed sum.
- Optionally applies the same low-bit truncation (HRDWIRED_BITWIDTH LSBs) as the adder when approximation is enabled.
- Presents the frame sum on a valid/ready output and reports a sticky saturation flag.
- Gives the approximate-adder characterisation path a registered, handshaked, per-frame aggregate instead of per-sample dumps.

---
 rtl/int_add_result_accumulator.sv | 171 +++++++++++++++++
 tb/tb_int_add_result_accumulator.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_add_result_accumulator.sv
// ---------------------------------------------------------------------------
// int_add_result_accumulator
//
// Purpose:
//   Collects the signed result stream of the approximate integer adder and
//   sums FRAME_LEN samples per frame into a wide, saturating signed
//   accumulator. When approximation is enabled for a frame, each sample has
//   its HRDWIRED_BITWIDTH LSBs cleared before it is added. The same truncation
//   is applied by the adder. The frame sum is offered on a valid/ready output
//   together with a sticky per-frame saturation flag.
//
// Ports:
//   clk       in   1                   rising-edge clock
//   rst       in   1                   synchronous active-high reset
//   apx_ctl   in   1                   truncate samples (sampled at frame start)
//   start     in   1                   request to begin a frame
//   in_valid  in   1                   in_data valid
//   in_ready  out  1                   sample accepted this cycle (ACCUM only)
//   in_data   in   DATA_PATH_BITWIDTH  signed adder result
//   out_valid out  1                   frame result valid (HOLD only)
//   out_ready in   1                   consumer accepts result
//   out_sum   out  ACC_BITWIDTH        signed frame sum
//   out_ovf   out  1                   saturation occurred in this frame
//   busy      out  1                   block is not idle
// ---------------------------------------------------------------------------
module int_add_result_accumulator #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int HRDWIRED_BITWIDTH  = 16,
    parameter int ACC_BITWIDTH       = 48,
    parameter int FRAME_LEN          = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          apx_ctl,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_BITWIDTH-1:0]       out_sum,
    output logic                          out_ovf,
    output logic                          busy
);

    // The counter only ever holds 0..FRAME_LEN-1 because the final accept
    // leaves ACCUM instead of storing FRAME_LEN.
    localparam int COUNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(FRAME_LEN - 1);

    localparam logic [ACC_BITWIDTH-1:0] ACC_MAX   = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
    localparam logic [ACC_BITWIDTH-1:0] ACC_MIN   = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};
    localparam logic [ACC_BITWIDTH-1:0] TRUNC_MASK = {ACC_BITWIDTH{1'b1}} << HRDWIRED_BITWIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [ACC_BITWIDTH-1:0]   acc, acc_next;
    logic [COUNT_W-1:0]        count, count_next;
    logic                      ovf, ovf_next;
    logic                      apx_lat, apx_lat_next;
    logic [ACC_BITWIDTH-1:0]   out_sum_next;
    logic                      out_ovf_next;

    logic [ACC_BITWIDTH-1:0]   operand_ext;
    logic [ACC_BITWIDTH-1:0]   operand;
    logic [ACC_BITWIDTH:0]     sum_wide;
    logic                      add_ovf;
    logic [ACC_BITWIDTH-1:0]   sat_sum;

    // Handshake and status outputs depend only on the registered state, so
    // nothing on the input side can reach an output combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    // Sign-extend the sample; clearing the low bits of a two's-complement
    // value rounds towards minus infinity, matching the adder's truncation.
    assign operand_ext = {{(ACC_BITWIDTH-DATA_PATH_BITWIDTH){in_data[DATA_PATH_BITWIDTH-1]}}, in_data};
    assign operand     = apx_lat ? (operand_ext & TRUNC_MASK) : operand_ext;

    // Add with one guard bit; the guard and the result MSB disagree exactly
    // when the true sum does not fit, and the guard bit gives the direction.
    assign sum_wide = {acc[ACC_BITWIDTH-1], acc} + {operand[ACC_BITWIDTH-1], operand};
    assign add_ovf  = sum_wide[ACC_BITWIDTH] ^ sum_wide[ACC_BITWIDTH-1];
    assign sat_sum  = !add_ovf               ? sum_wide[ACC_BITWIDTH-1:0] :
                      sum_wide[ACC_BITWIDTH] ? ACC_MIN : ACC_MAX;

    // Next-state and datapath update. A frame start (from IDLE, or directly
    // from HOLD on a completed handshake with start) clears the running sum
    // and latches the approximation mode for the whole frame.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        count_next   = count;
        ovf_next     = ovf;
        apx_lat_next = apx_lat;
        out_sum_next = out_sum;
        out_ovf_next = out_ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ACCUM;
                    acc_next     = '0;
                    count_next   = '0;
                    ovf_next     = 1'b0;
                    apx_lat_next = apx_ctl;
                end
            end

            ACCUM: begin
                if (in_valid) begin
                    acc_next   = sat_sum;
                    ovf_next   = ovf | add_ovf;
                    count_next = count + 1'b1;
                    if (count == LAST_COUNT) begin
                        out_sum_next = sat_sum;
                        out_ovf_next = ovf | add_ovf;
                        state_next   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_next   = ACCUM;
                        acc_next     = '0;
                        count_next   = '0;
                        ovf_next     = 1'b0;
                        apx_lat_next = apx_ctl;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset wins over everything and throws away any
    // partial frame or unread result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            apx_lat <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            count   <= count_next;
            ovf     <= ovf_next;
            apx_lat <= apx_lat_next;
            out_sum <= out_sum_next;
            out_ovf <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_int_add_result_accumulator.sv
// ---------------------------------------------------------------------------
// tb_int_add_result_accumulator
//
// Purpose:
//   Self-checking bench for int_add_result_accumulator. A default instance
//   (48-bit accumulator, 8-sample frames) runs a table of frames plus
//   hand-written backpressure and reset sequences. A second instance with
//   a 33-bit accumulator and 4-sample frames exercises saturation, because
//   four full-scale samples can overflow a 33-bit sum.
// ---------------------------------------------------------------------------
module tb_int_add_result_accumulator;

    localparam int FRAME   = 8;
    localparam int S_FRAME = 4;
    localparam int S_ACC   = 33;

    logic        clk;
    logic        rst;
    logic        apx_ctl;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_sum;
    logic        out_ovf;
    logic        busy;

    logic             s_start;
    logic             s_in_valid;
    logic             s_in_ready;
    logic [31:0]      s_in_data;
    logic             s_out_valid;
    logic             s_out_ready;
    logic [S_ACC-1:0] s_out_sum;
    logic             s_out_ovf;
    logic             s_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic                  apx;
        logic                  gaps;
        logic [FRAME-1:0][31:0] data;
        longint                exp_sum;
        logic                  exp_ovf;
    } vec_t;

    vec_t vecs[7];

    int_add_result_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .apx_ctl   (apx_ctl),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    int_add_result_accumulator #(
        .DATA_PATH_BITWIDTH (32),
        .HRDWIRED_BITWIDTH  (16),
        .ACC_BITWIDTH       (S_ACC),
        .FRAME_LEN          (S_FRAME)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .apx_ctl   (apx_ctl),
        .start     (s_start),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_sum   (s_out_sum),
        .out_ovf   (s_out_ovf),
        .busy      (s_busy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hang anywhere in the sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Raises start for one cycle from IDLE; afterwards the block is in ACCUM.
    task automatic applyStimulus(input logic apx);
        apx_ctl = apx;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", longint'(busy), 1);
        checkOutput("in_ready_after_start", longint'(in_ready), 1);
    endtask

    // Feeds one frame (optionally with random stalls carrying junk data) and
    // flips apx_ctl halfway through, which must not change the result.
    task automatic feedFrame(input vec_t v);
        int  idx     = 0;
        int  cycles  = 0;
        bit  toggled = 1'b0;
        while (idx < FRAME && cycles < 200) begin
            if (v.gaps && ($urandom_range(0, 1) == 0)) begin
                in_valid = 1'b0;
                in_data  = 32'h7FFF_FFFF;
            end else begin
                in_valid = 1'b1;
                in_data  = v.data[idx];
                checkOutput("in_ready_during_frame", longint'(in_ready), 1);
                checkOutput("out_valid_during_frame", longint'(out_valid), 0);
                idx++;
            end
            if (idx == FRAME / 2 && !toggled) begin
                apx_ctl = ~apx_ctl;
                toggled = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
        if (idx < FRAME) checkOutput("feed_timeout_accepts", longint'(idx), FRAME);
    endtask

    // Result must be presented one cycle after the last accept.
    task automatic checkResult(input vec_t v);
        checkOutput("out_valid_latency", longint'(out_valid), 1);
        checkOutput("out_sum", longint'($signed(out_sum)), v.exp_sum);
        checkOutput("out_ovf", longint'(out_ovf), longint'(v.exp_ovf));
        checkOutput("in_ready_in_hold", longint'(in_ready), 0);
        checkOutput("busy_in_hold", longint'(busy), 1);
    endtask

    // Completes the output handshake and checks the return to IDLE.
    task automatic handshake(input longint exp_sum);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_after_handshake", longint'(out_valid), 0);
        checkOutput("busy_after_handshake", longint'(busy), 0);
        checkOutput("out_sum_retained", longint'($signed(out_sum)), exp_sum);
    endtask

    // Complete frame on the 33-bit / 4-sample instance.
    task automatic smallFrame(input logic [S_FRAME-1:0][31:0] d, input longint exp_sum,
                              input logic exp_ovf);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < S_FRAME; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = d[i];
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        checkOutput("s_out_valid", longint'(s_out_valid), 1);
        checkOutput("s_out_sum", longint'($signed(s_out_sum)), exp_sum);
        checkOutput("s_out_ovf", longint'(s_out_ovf), longint'(exp_ovf));
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        checkOutput("s_out_valid_after_handshake", longint'(s_out_valid), 0);
    endtask

    // Main sequence.
    initial begin
        logic [S_FRAME-1:0][31:0] sd;

        // Frame table: plain 1..8, truncation cancelling to zero,
        // full-scale negative, truncated positive, and -100 with stalls.
        // The last two entries are used by the hand-written sequences.
        for (int k = 0; k < 7; k++) begin
            vecs[k].apx     = 1'b0;
            vecs[k].gaps    = 1'b0;
            vecs[k].data    = '0;
            vecs[k].exp_sum = 0;
            vecs[k].exp_ovf = 1'b0;
        end
        for (int i = 0; i < FRAME; i++) begin
            vecs[0].data[i] = 32'(i + 1);
            vecs[1].data[i] = (i < 4) ? 32'h0001_FFFF : 32'hFFFF_FFFF;
            vecs[2].data[i] = 32'h8000_0000;
            vecs[3].data[i] = 32'h0001_2345;
            vecs[5].data[i] = 32'd2;
            vecs[6].data[i] = 32'd5;
        end
        vecs[0].exp_sum = 36;
        vecs[1].apx     = 1'b1;
        vecs[1].exp_sum = 0;
        vecs[2].exp_sum = -64'sd17179869184;
        vecs[3].apx     = 1'b1;
        vecs[3].exp_sum = 524288;
        vecs[4].gaps    = 1'b1;
        vecs[4].data    = {32'h0000_0000, 32'hFFFF_FFE7, 32'hFFFF_FFFB, 32'hFFFF_FFF1,
                           32'hFFFF_FFE2, 32'h0000_0005, 32'hFFFF_FFEC, 32'hFFFF_FFF6};
        vecs[4].exp_sum = -100;
        vecs[5].exp_sum = 16;
        vecs[6].exp_sum = 40;

        rst         = 1'b1;
        apx_ctl     = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0;
        out_ready   = 1'b0;
        s_start     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = 32'h0;
        s_out_ready = 1'b0;
        sd          = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_busy", longint'(busy), 0);
        checkOutput("reset_in_ready", longint'(in_ready), 0);
        checkOutput("reset_out_valid", longint'(out_valid), 0);
        checkOutput("reset_out_sum", longint'($signed(out_sum)), 0);
        checkOutput("reset_out_ovf", longint'(out_ovf), 0);

        $display("[TB] table-driven frames");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k].apx);
            feedFrame(vecs[k]);
            checkResult(vecs[k]);
            handshake(vecs[k].exp_sum);
        end

        $display("[TB] backpressure and back-to-back start");
        applyStimulus(1'b0);
        feedFrame(vecs[0]);
        checkResult(vecs[0]);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 32'd999;
            @(negedge clk);
            checkOutput("bp_out_valid", longint'(out_valid), 1);
            checkOutput("bp_out_sum", longint'($signed(out_sum)), 36);
            checkOutput("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        checkOutput("bp_start_without_ready", longint'(out_valid), 1);
        apx_ctl   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_out_valid", longint'(out_valid), 0);
        checkOutput("b2b_in_ready", longint'(in_ready), 1);
        checkOutput("b2b_busy", longint'(busy), 1);
        checkOutput("b2b_out_sum_retained", longint'($signed(out_sum)), 36);
        feedFrame(vecs[5]);
        checkResult(vecs[5]);
        handshake(vecs[5].exp_sum);

        $display("[TB] saturation on narrow instance");
        apx_ctl = 1'b0;
        sd = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        smallFrame(sd, 64'sd4294967295, 1'b1);
        sd = {32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        smallFrame(sd, 64'sd2147483647, 1'b1);
        sd = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        smallFrame(sd, -64'sd4294967296, 1'b1);
        sd = {32'd4, 32'd3, 32'd2, 32'd1};
        smallFrame(sd, 10, 1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd100;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", longint'(busy), 0);
        checkOutput("midrst_in_ready", longint'(in_ready), 0);
        checkOutput("midrst_out_valid", longint'(out_valid), 0);
        checkOutput("midrst_out_sum", longint'($signed(out_sum)), 0);
        checkOutput("midrst_out_ovf", longint'(out_ovf), 0);
        applyStimulus(1'b0);
        feedFrame(vecs[6]);
        checkResult(vecs[6]);
        handshake(vecs[6].exp_sum);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
